pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the PC and all address ports.
REQ-002 Parameter STEP, default 4: sequential increment added to PC.
REQ-003 Parameter DEPTH, default 4: return-address stack (RAS) entries; power of two, >=2.
REQ-004 CLK  input  1  clock; all state updates on the falling edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 RST_VEC  input  WIDTH  value loaded into PC while RST is high.
REQ-007 WE  input  1  PC write enable; when low, PC and RAS hold.
REQ-008 SEL  input  2  next-PC mode: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RETURN.
REQ-009 OFFSET  input  WIDTH  branch displacement, two's complement.
REQ-010 TARGET  input  WIDTH  absolute jump target, and fallback address for RETURN on an empty RAS.
REQ-011 CALL  input  1  push the link address onto the RAS; honoured only when WE=1 and SEL is 01 or 10.
REQ-012 PC  output  WIDTH  current program counter, registered.
REQ-013 PC_NEXT  output  WIDTH  combinational next-PC value for the current SEL.
REQ-014 RAS_EMPTY  output  1  RAS holds 0 entries.
REQ-015 RAS_FULL  output  1  RAS holds DEPTH entries.
REQ-016 RAS_ERR  output  2  sticky flags: bit0 = overflow, bit1 = underflow.

Function
REQ-017 Link address LINK = PC+STEP, computed modulo 2^WIDTH.
REQ-018 PC_NEXT for each SEL:
  - SEQ: LINK.
  - BRANCH: LINK+OFFSET, modulo 2^WIDTH, wrap-around permitted.
  - JUMP: TARGET.
  - RETURN: RAS top entry if the RAS is non-empty, else TARGET.
REQ-019 On a falling CLK edge with WE=1, PC takes PC_NEXT; latency is one edge.
REQ-020 On a falling CLK edge with WE=0, PC, RAS contents, pointer, count and RAS_ERR hold, regardless of SEL and CALL.
REQ-021 RAS is a circular buffer with a write pointer and an entry count (0..DEPTH).
REQ-022 Push (CALL honoured): LINK is written at the pointer, the pointer increments modulo DEPTH, and count increments saturating at DEPTH.
REQ-023 Push when full: the oldest entry is overwritten, count stays DEPTH, and RAS_ERR[0] is set.
REQ-024 Pop (WE=1, SEL=11, non-empty): PC takes the top entry, the pointer decrements modulo DEPTH, and count decrements.
REQ-025 Pop when empty: PC takes TARGET, pointer and count are unchanged, and RAS_ERR[1] is set.
REQ-026 CALL with SEL=00 or SEL=11 is ignored; a push and a pop never occur on the same edge.
REQ-027 RAS_EMPTY is (count==0) and RAS_FULL is (count==DEPTH), both derived from registered state with no extra latency.
REQ-028 RAS_ERR bits, once set, remain set until reset.

Reset
REQ-029 While RST is high, asynchronously and independent of CLK:
  - PC = RST_VEC, tracking RST_VEC combinationally-registered.
  - RAS count and pointer = 0, so RAS_EMPTY=1 and RAS_FULL=0.
  - RAS_ERR = 00.
REQ-030 RAS entry contents are don't-care after reset and are never observable while the RAS is empty.
REQ-031 Reset asserted mid-sequence discards any pending update; the first falling edge after RST deasserts follows REQ-019/020.
REQ-032 Initial simulation value of PC is 0 before the first reset.

Verification
REQ-033 RST=1, RST_VEC=0x100, then release; 3 edges WE=1 SEL=00 -> PC = 0x100, 0x104, 0x108, 0x10C.
REQ-034 PC=0x200, SEL=01, OFFSET=0xFFFFFFF0 -> PC=0x1F4; PC=0xFFFFFFFC, SEL=00 -> PC=0x0.
REQ-035 PC=0x40, SEL=10, CALL=1, TARGET=0x800 -> PC=0x800, RAS holds 0x44; then SEL=11 -> PC=0x44, RAS_EMPTY=1.
REQ-036 Five CALLs with DEPTH=4 (links L1..L5) -> RAS_FULL=1, RAS_ERR=01; four RETURNs -> L5, L4, L3, L2.
REQ-037 RETURN on empty RAS with TARGET=0x300 -> PC=0x300, RAS_ERR[1]=1, RAS_EMPTY stays 1.
REQ-038 WE=0 with SEL=11, CALL=1 for 3 edges -> PC, RAS state and flags unchanged; RST pulse between edges -> PC=RST_VEC immediately, RAS_ERR=00.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/return selection and a circular
// return-address stack; all state updates on the falling clock edge.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RST_VEC,
  input  logic             WE,
  input  logic [1:0]       SEL,
  input  logic [WIDTH-1:0] OFFSET,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             CALL,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_NEXT,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic [1:0]       RAS_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_RETURN = 2'b11;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] ras_q [DEPTH];

  logic [WIDTH-1:0] pc_s;
  logic [WIDTH-1:0] link_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] pc_next_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  // While RST is high the visible PC follows RST_VEC without waiting for a clock.
  assign pc_s    = RST ? RST_VEC : pc_q;
  assign link_s  = pc_s + WIDTH'(STEP);
  assign top_s   = ras_q[ptr_q - AW'(1)];
  assign empty_s = (cnt_q == CW'(0));
  assign full_s  = (cnt_q == CW'(DEPTH));
  assign push_s  = WE & CALL & ((SEL == SEL_BRANCH) | (SEL == SEL_JUMP));
  assign pop_s   = WE & (SEL == SEL_RETURN);

  always_comb begin
    pc_next_s = link_s;
    case (SEL)
      SEL_SEQ:    pc_next_s = link_s;
      SEL_BRANCH: pc_next_s = link_s + OFFSET;
      SEL_JUMP:   pc_next_s = TARGET;
      SEL_RETURN: pc_next_s = empty_s ? TARGET : top_s;
      default:    pc_next_s = link_s;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (WE) begin
      pc_d = pc_next_s;
      if (push_s) begin
        // A full stack overwrites its oldest slot, which is exactly where ptr points.
        ptr_d = ptr_q + AW'(1);
        if (full_s) begin
          err_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (pop_s) begin
        if (empty_s) begin
          err_d[1] = 1'b1;
        end else begin
          ptr_d = ptr_q - AW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      pc_q  <= RST_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 2'b00;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage needs no reset: it is unreadable until something is pushed.
  always_ff @(negedge CLK) begin
    if (!RST && push_s) begin
      ras_q[ptr_q] <= link_s;
    end
  end

  assign PC        = pc_s;
  assign PC_NEXT   = pc_next_s;
  assign RAS_EMPTY = empty_s;
  assign RAS_FULL  = full_s;
  assign RAS_ERR   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a reference model pushes expectations per edge,
// each scenario task pops and compares after the falling edge.
module tb_pc_unit;

  logic        CLK, RST, WE, CALL;
  logic [31:0] RST_VEC, OFFSET, TARGET;
  logic [1:0]  SEL;
  logic [31:0] PC, PC_NEXT;
  logic        RAS_EMPTY, RAS_FULL;
  logic [1:0]  RAS_ERR;

  pc_unit dut (
    .CLK(CLK), .RST(RST), .RST_VEC(RST_VEC), .WE(WE), .SEL(SEL),
    .OFFSET(OFFSET), .TARGET(TARGET), .CALL(CALL), .PC(PC), .PC_NEXT(PC_NEXT),
    .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL), .RAS_ERR(RAS_ERR)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        emp;
    logic        full;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic [1:0]  m_err;
  logic [31:0] obs_next;

  task automatic model_reset(input logic [31:0] vec);
    m_pc = vec;
    m_stk.delete();
    m_err = 2'b00;
  endtask

  // Apply one cycle of stimulus, predict the result, let the falling edge happen.
  task automatic drive(input logic we, input logic [1:0] sel, input logic [31:0] off,
                       input logic [31:0] tgt, input logic call);
    logic [31:0] link, nxt;
    exp_t x;
    WE = we; SEL = sel; OFFSET = off; TARGET = tgt; CALL = call;
    link = m_pc + 32'd4;
    case (sel)
      2'b00:   nxt = link;
      2'b01:   nxt = link + off;
      2'b10:   nxt = tgt;
      default: nxt = (m_stk.size() != 0) ? m_stk[$] : tgt;
    endcase
    x.nxt = nxt;
    if (we) begin
      if (sel == 2'b11) begin
        if (m_stk.size() != 0) void'(m_stk.pop_back());
        else m_err[1] = 1'b1;
      end else if (call && (sel != 2'b00)) begin
        if (m_stk.size() == 4) begin
          void'(m_stk.pop_front());
          m_err[0] = 1'b1;
        end
        m_stk.push_back(link);
      end
      m_pc = nxt;
    end
    x.pc = m_pc; x.emp = (m_stk.size() == 0); x.full = (m_stk.size() == 4); x.err = m_err;
    sb_q.push_back(x);
    #1 obs_next = PC_NEXT;
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; RST_VEC = 32'h100; WE = 1'b1; SEL = 2'b00; CALL = 1'b0;
    OFFSET = 32'h0; TARGET = 32'h0;
    #2;
    n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, 32'h100); end
    n_cmp++; if ({RAS_EMPTY, RAS_FULL, RAS_ERR} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags: got %b want %b", {RAS_EMPTY, RAS_FULL, RAS_ERR}, 4'b1000); end
    RST_VEC = 32'h180;
    #1;
    n_cmp++; if (PC !== 32'h180) begin n_err++; $display("FAIL reset_track: got %h want %h", PC, 32'h180); end
    RST_VEC = 32'h100;
    @(negedge CLK); @(negedge CLK);
    #1;
    n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL reset_hold_edges: got %h want %h", PC, 32'h100); end
    RST = 1'b0;
    model_reset(32'h100);
  endtask

  task automatic test_seq;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
      e = sb_q.pop_front();
      n_cmp++; if (PC !== e.pc) begin n_err++; $display("FAIL seq_pc: got %h want %h", PC, e.pc); end
      n_cmp++; if (PC !== 32'h100 + 32'(4 * i)) begin
        n_err++; $display("FAIL seq_abs: got %h want %h", PC, 32'h100 + 32'(4 * i)); end
      n_cmp++; if (obs_next !== e.nxt) begin n_err++; $display("FAIL seq_next: got %h want %h", obs_next, e.nxt); end
    end
  endtask

  task automatic test_branch;
    logic [1:0]  sel_t [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
    logic [31:0] off_t [4] = '{32'h0, 32'hFFFF_FFF0, 32'h0, 32'h0};
    logic [31:0] tgt_t [4] = '{32'h200, 32'h0, 32'hFFFF_FFFC, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, sel_t[i], off_t[i], tgt_t[i], 1'b0);
      e = sb_q.pop_front();
      n_cmp++; if (PC !== e.pc) begin n_err++; $display("FAIL branch_pc[%0d]: got %h want %h", i, PC, e.pc); end
      n_cmp++; if (obs_next !== e.nxt) begin
        n_err++; $display("FAIL branch_next[%0d]: got %h want %h", i, obs_next, e.nxt); end
    end
    n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want %h", PC, 32'h0); end
  endtask

  task automatic test_call_return;
    drive(1'b1, 2'b10, 32'h0, 32'h40, 1'b0);
    e = sb_q.pop_front();
    drive(1'b1, 2'b10, 32'h0, 32'h800, 1'b1);
    e = sb_q.pop_front();
    n_cmp++; if (PC !== e.pc || RAS_EMPTY !== e.emp) begin
      n_err++; $display("FAIL call_pc: got %h/%b want %h/%b", PC, RAS_EMPTY, e.pc, e.emp); end
    drive(1'b1, 2'b11, 32'h0, 32'h999, 1'b0);
    e = sb_q.pop_front();
    n_cmp++; if (obs_next !== 32'h44) begin n_err++; $display("FAIL ret_next: got %h want %h", obs_next, 32'h44); end
    n_cmp++; if (PC !== e.pc || RAS_EMPTY !== 1'b1) begin
      n_err++; $display("FAIL ret_pc: got %h/%b want %h/1", PC, RAS_EMPTY, e.pc); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b10, 32'h0, 32'h1000 + 32'(i * 32'h100), 1'b1);
      e = sb_q.pop_front();
      n_cmp++; if ({RAS_EMPTY, RAS_FULL, RAS_ERR} !== {e.emp, e.full, e.err}) begin
        n_err++; $display("FAIL push_flags[%0d]: got %b want %b", i, {RAS_EMPTY, RAS_FULL, RAS_ERR},
                          {e.emp, e.full, e.err}); end
    end
    n_cmp++; if ({RAS_FULL, RAS_ERR} !== 3'b101) begin
      n_err++; $display("FAIL overflow: got %b want %b", {RAS_FULL, RAS_ERR}, 3'b101); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11, 32'h0, 32'h0, 1'b0);
      e = sb_q.pop_front();
      n_cmp++; if (PC !== e.pc) begin n_err++; $display("FAIL pop_pc[%0d]: got %h want %h", i, PC, e.pc); end
    end
  endtask

  task automatic test_empty_return;
    drive(1'b1, 2'b11, 32'h0, 32'h300, 1'b0);
    e = sb_q.pop_front();
    n_cmp++; if (PC !== 32'h300 || PC !== e.pc) begin
      n_err++; $display("FAIL empty_ret_pc: got %h want %h", PC, 32'h300); end
    n_cmp++; if ({RAS_EMPTY, RAS_ERR} !== {1'b1, e.err} || RAS_ERR[1] !== 1'b1) begin
      n_err++; $display("FAIL empty_ret_flags: got %b want %b", {RAS_EMPTY, RAS_ERR}, {1'b1, e.err}); end
  endtask

  task automatic test_hold;
    drive(1'b1, 2'b01, 32'h20, 32'h0, 1'b1);
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, 32'h0, 32'h0, 1'b1);
      e = sb_q.pop_front();
      n_cmp++; if ({PC, RAS_EMPTY, RAS_FULL, RAS_ERR} !== {e.pc, e.emp, e.full, e.err}) begin
        n_err++; $display("FAIL hold[%0d]: got %h/%b want %h/%b", i, PC, {RAS_EMPTY, RAS_FULL, RAS_ERR},
                          e.pc, {e.emp, e.full, e.err}); end
      n_cmp++; if (obs_next !== e.nxt) begin n_err++; $display("FAIL hold_next[%0d]: got %h want %h", i, obs_next, e.nxt); end
    end
    WE = 1'b1; SEL = 2'b10; TARGET = 32'h777; CALL = 1'b1;
    #2 RST_VEC = 32'h500; RST = 1'b1;
    #1;
    n_cmp++; if (PC !== 32'h500 || {RAS_EMPTY, RAS_FULL, RAS_ERR} !== 4'b1000) begin
      n_err++; $display("FAIL rst_pulse: got %h/%b want %h/%b", PC, {RAS_EMPTY, RAS_FULL, RAS_ERR}, 32'h500, 4'b1000); end
    #1 RST = 1'b0;
    model_reset(32'h500);
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    e = sb_q.pop_front();
    n_cmp++; if (PC !== 32'h504 || PC !== e.pc) begin n_err++; $display("FAIL post_rst: got %h want %h", PC, 32'h504); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 32'($urandom) & 32'h0000_0FFC,
            32'($urandom) & 32'h0000_FFFC, 1'($urandom_range(0, 1)));
      e = sb_q.pop_front();
      n_cmp++; if ({PC, obs_next, RAS_EMPTY, RAS_FULL, RAS_ERR} !== {e.pc, e.nxt, e.emp, e.full, e.err}) begin
        n_err++; $display("FAIL rand[%0d]: got %h %h %b want %h %h %b", i, PC, obs_next,
                          {RAS_EMPTY, RAS_FULL, RAS_ERR}, e.pc, e.nxt, {e.emp, e.full, e.err}); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_call_return();
    test_overflow();
    test_empty_return();
    test_hold();
    test_back_to_back();
    n_cmp++; if (sb_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
